// File: rtl/rim_dfs_solver.sv
// rim_dfs_solver
//   Rat-in-a-maze solver. An N x N maze is loaded one row per in_valid beat,
//   then a depth-first search with backtracking finds a path from (0,0) to
//   (N-1,N-1). The path is streamed out one coordinate per cycle, or a one-cycle
//   no_path pulse is raised when the goal cannot be reached.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid, maze    row beat; maze bit N-1 is column 0, 1 = open, 0 = wall
//   out_valid         path coordinate valid (out_row, out_col)
//   out_last          marks the goal coordinate, the final beat
//   no_path           one-cycle pulse when no path exists
//   busy              high from the first SEARCH cycle to the last OUTPUT/FAIL cycle
module rim_dfs_solver #(
  parameter int N   = 8,
  parameter int CW  = $clog2(N),
  parameter int SPW = $clog2(N*N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [N-1:0]  maze,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  output logic          no_path,
  output logic          busy
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;
  localparam logic [1:0] S_FAIL   = 2'd3;

  localparam int             SIW   = $clog2(N*N);
  localparam logic [CW-1:0]  LASTC = CW'(N-1);
  localparam logic [CW:0]    NX    = (CW+1)'(N);

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] c;
  } coord_t;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [SPW-1:0]       sp, oidx;
  logic [N-1:0][N-1:0]  rows;   // rows[r][N-1-c] = open
  logic [N-1:0][N-1:0]  vis;    // vis[r][c]
  coord_t               stk [N*N];

  coord_t               top, nb, stk_wd;
  logic                 nb_ok, at_goal, start_open, load_done, push, stk_we;
  logic [SIW-1:0]       stk_wi;
  logic [CW:0]          tr, tc, r2, c2;

  assign top        = stk[SIW'(sp - SPW'(1))];
  assign at_goal    = (top.r == LASTC) && (top.c == LASTC);
  assign start_open = rows[0][N-1];
  assign busy       = (state != S_LOAD);

  // Neighbour selection in priority down, right, up, left. Coordinates carry
  // one extra bit so 0-1 becomes a large value and N-1+1 becomes N; both then
  // fail the single "< N" bounds test.
  always_comb begin
    nb_ok = 1'b0;
    nb    = '0;
    tr    = {1'b0, top.r};
    tc    = {1'b0, top.c};
    r2    = tr;
    c2    = tc;
    for (int d = 0; d < 4; d++) begin
      r2 = tr;
      c2 = tc;
      case (d)
        0:       r2 = tr + 1'b1;
        1:       c2 = tc + 1'b1;
        2:       r2 = tr - 1'b1;
        default: c2 = tc - 1'b1;
      endcase
      if (!nb_ok && (r2 < NX) && (c2 < NX) &&
          rows[r2[CW-1:0]][LASTC - c2[CW-1:0]] &&
          !vis[r2[CW-1:0]][c2[CW-1:0]]) begin
        nb_ok = 1'b1;
        nb.r  = r2[CW-1:0];
        nb.c  = c2[CW-1:0];
      end
    end
  end

  // Single stack write port: seed (0,0) on load completion, or push a neighbour.
  assign load_done = (state == S_LOAD) && in_valid && (cnt == LASTC);
  assign push      = (state == S_SEARCH) && start_open && !at_goal && nb_ok;
  assign stk_we    = load_done || push;
  assign stk_wi    = load_done ? '0 : SIW'(sp);
  assign stk_wd    = load_done ? '0 : nb;

  always_ff @(posedge clk) begin
    if (stk_we) stk[stk_wi] <= stk_wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      cnt       <= '0;
      sp        <= '0;
      oidx      <= '0;
      rows      <= '0;
      vis       <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      no_path   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            rows[cnt] <= maze;
            if (load_done) begin
              cnt       <= '0;
              sp        <= SPW'(1);
              vis       <= '0;
              vis[0][0] <= 1'b1;
              state     <= S_SEARCH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_SEARCH: begin
          if (!start_open) begin
            no_path <= 1'b1;
            state   <= S_FAIL;
          end else if (at_goal) begin
            // First beat leaves with the state change so it lands in the
            // first OUTPUT cycle.
            out_valid <= 1'b1;
            out_row   <= stk[0].r;
            out_col   <= stk[0].c;
            out_last  <= (sp == SPW'(1));
            oidx      <= SPW'(1);
            state     <= S_OUTPUT;
          end else if (nb_ok) begin
            sp              <= sp + 1'b1;
            vis[nb.r][nb.c] <= 1'b1;
          end else begin
            sp <= sp - 1'b1;
            if (sp == SPW'(1)) begin
              no_path <= 1'b1;
              state   <= S_FAIL;
            end
          end
        end
        S_OUTPUT: begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            sp        <= '0;
            state     <= S_LOAD;
          end else begin
            out_row  <= stk[SIW'(oidx)].r;
            out_col  <= stk[SIW'(oidx)].c;
            out_last <= (oidx == sp - SPW'(1));
            oidx     <= oidx + 1'b1;
          end
        end
        default: begin
          no_path <= 1'b0;
          sp      <= '0;
          state   <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rim_dfs_solver.sv
// tb_rim_dfs_solver
//   Drives an N=8 and an N=4 solver from one stimulus stream and compares the
//   streamed path, latency and pulses against a queue-based DFS model.
module tb_rim_dfs_solver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv  = 1'b0;
  logic [7:0] mz  = '0;
  bit         use4 = 1'b0;

  logic       iv8, iv4;
  logic [3:0] mz4;
  logic       ov8, ol8, np8, b8;
  logic [2:0] or8, oc8;
  logic       ov4, ol4, np4, b4;
  logic [1:0] or4, oc4;

  assign iv8 = iv && !use4;
  assign iv4 = iv && use4;
  assign mz4 = mz[3:0];

  rim_dfs_solver #(.N(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .maze(mz),
    .out_valid(ov8), .out_row(or8), .out_col(oc8), .out_last(ol8),
    .no_path(np8), .busy(b8));

  rim_dfs_solver #(.N(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .maze(mz4),
    .out_valid(ov4), .out_row(or4), .out_col(oc4), .out_last(ol4),
    .no_path(np4), .busy(b4));

  wire       s_ov  = use4 ? ov4 : ov8;
  wire       s_ol  = use4 ? ol4 : ol8;
  wire       s_np  = use4 ? np4 : np8;
  wire       s_b   = use4 ? b4  : b8;
  wire [2:0] s_row = use4 ? {1'b0, or4} : or8;
  wire [2:0] s_col = use4 ? {1'b0, oc4} : oc8;

  always #5 clk = ~clk;

  int         nvec = 0, nerr = 0;
  logic [7:0] rows [8];
  int         exp_r[$], exp_c[$];
  bit         exp_found;
  int         exp_act;
  int         ob_r[$], ob_c[$], ob_l[$];

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit op(input int n, input int r, input int c);
    return rows[r][n-1-c];
  endfunction

  // DFS over a cell stack; exp_act counts search actions (one per cycle).
  task automatic model(input int n);
    bit vis [8][8];
    int sr[$], sc[$];
    int dr[4] = '{1, 0, -1, 0};
    int dc[4] = '{0, 1, 0, -1};
    exp_r.delete(); exp_c.delete();
    exp_found = 0; exp_act = 0;
    vis = '{default: '0};
    sr.push_back(0); sc.push_back(0); vis[0][0] = 1;
    if (!op(n, 0, 0)) begin exp_act = 1; return; end
    forever begin
      int r, c;
      bit moved;
      exp_act++;
      r = sr[$]; c = sc[$];
      if (r == n-1 && c == n-1) begin
        exp_found = 1; exp_r = sr; exp_c = sc; return;
      end
      moved = 0;
      for (int d = 0; d < 4 && !moved; d++) begin
        int nr, nc;
        nr = r + dr[d]; nc = c + dc[d];
        if (nr >= 0 && nr < n && nc >= 0 && nc < n && op(n, nr, nc) && !vis[nr][nc]) begin
          vis[nr][nc] = 1; sr.push_back(nr); sc.push_back(nc); moved = 1;
        end
      end
      if (!moved) begin
        void'(sr.pop_back()); void'(sc.pop_back());
        if (sr.size() == 0) return;
      end
    end
  endtask

  task automatic load(input int n, input bit gaps);
    use4 = (n == 4);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk); iv = 1'b0; mz = 8'($urandom);
      end
      @(negedge clk); iv = 1'b1; mz = rows[i];
    end
  endtask

  task automatic run(input string tag, input int n, input bit gaps, input bit junk, output int t_evt);
    int t, budget, np_cnt, idle_bad;
    bit done;
    model(n);
    ob_r.delete(); ob_c.delete(); ob_l.delete();
    load(n, gaps);
    t = 0; done = 0; np_cnt = 0; idle_bad = 0; t_evt = -1;
    budget = 3*n*n + 10;
    while (!done && t < budget) begin
      @(negedge clk); t++;
      if (t == 1) chk({tag, " busy"}, s_b, 1);
      if (s_ov) begin
        if (ob_r.size() == 0) t_evt = t;
        ob_r.push_back(s_row); ob_c.push_back(s_col); ob_l.push_back(s_ol);
        if (s_ol) done = 1;
      end else if (s_row != 0 || s_col != 0 || s_ol) idle_bad++;
      if (s_np) begin np_cnt++; t_evt = t; done = 1; end
      iv = (junk && !done) ? 1'($urandom) : 1'b0;
      mz = 8'($urandom);
    end
    chk({tag, " finished"}, done, 1);
    chk({tag, " found"}, ob_r.size() > 0, exp_found);
    chk({tag, " no_path count"}, np_cnt, exp_found ? 0 : 1);
    chk({tag, " latency"}, t_evt, exp_act + 1);
    if (exp_found) begin
      chk({tag, " length"}, ob_r.size(), exp_r.size());
      for (int i = 0; i < ob_r.size() && i < exp_r.size(); i++)
        chk({tag, " beat rc*100+col*10+last"}, ob_r[i]*100 + ob_c[i]*10 + ob_l[i],
            exp_r[i]*100 + exp_c[i]*10 + int'(i == exp_r.size()-1));
    end
    chk({tag, " idle outputs"}, idle_bad, 0);
    @(negedge clk);
    chk({tag, " back to idle"}, int'({s_ov, s_np, s_b}), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, int'({s_ov, s_ol, s_np, s_b, s_row, s_col}), 0);
  endtask

  function automatic void fill(input logic [7:0] v);
    for (int r = 0; r < 8; r++) rows[r] = v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset N8", int'({ov8, ol8, np8, b8, or8, oc8}), 0);
    chk("reset N4", int'({ov4, ol4, np4, b4, or4, oc4}), 0);
    rst = 1'b0;
    @(negedge clk);

    fill(8'hFF);
    run("T1", 8, 0, 0, t);
    chk("T1 beats", ob_r.size(), 15);
    chk("T1 first beat time", t, 16);

    fill(8'hFF); rows[0] = 8'h7F;
    run("T2", 8, 0, 0, t);
    chk("T2 pulse time", t, 2);

    rows[0] = 8'hF; rows[1] = 8'h9; rows[2] = 8'h1; rows[3] = 8'h1;
    run("T3", 4, 0, 0, t);
    chk("T3 beats", ob_r.size(), 7);

    rows[0] = 8'hF; rows[1] = 8'h0; rows[2] = 8'hF; rows[3] = 8'hF;
    run("T4a", 4, 0, 0, t);
    chk("T4a within bound", int'(t >= 2 && t <= 34), 1);
    rows[0] = 8'hF; rows[1] = 8'hF; rows[2] = 8'hF; rows[3] = 8'hE;
    run("T4b", 4, 0, 0, t);
    chk("T4b within bound", int'(t >= 2 && t <= 34), 1);

    fill(8'hFF);
    run("T5 gaps", 8, 1, 1, t);
    chk("T5 beats", ob_r.size(), 15);
    rows[0] = 8'hF; rows[1] = 8'h9; rows[2] = 8'h1; rows[3] = 8'h1;
    run("T5 N4", 4, 1, 1, t);

    for (int k = 0; k < 10; k++) begin
      for (int r = 0; r < 8; r++) rows[r] = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin rows[0][7] = 1'b1; rows[7][0] = 1'b1; end
      run("R8", 8, 1'($urandom), 1'($urandom), t);
    end
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 4; r++) rows[r] = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin rows[0][3] = 1'b1; rows[3][0] = 1'b1; end
      run("R4", 4, 1'($urandom), 1'($urandom), t);
    end

    // Reset mid-search
    fill(8'hFF);
    load(8, 0);
    @(negedge clk); iv = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle("T6 reset in search");
    @(negedge clk); rst = 1'b0;

    // Reset mid-output, a few beats into the stream
    load(8, 0);
    @(negedge clk); iv = 1'b0;
    w = 0;
    while (!s_ov && w < 100) begin @(negedge clk); w++; end
    chk("T6 output reached", s_ov, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle("T6 reset in output");
    @(negedge clk); rst = 1'b0;

    fill(8'hFF);
    run("T6 reload", 8, 0, 0, t);
    chk("T6 beats", ob_r.size(), 15);
    chk("T6 first beat time", t, 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
